// File: rtl/class_hv_accumulator.sv
// rtl/class_hv_accumulator.sv - per-class saturating hypervector accumulators with binarized readout
module class_hv_accumulator #(
    parameter int DIM         = 50,
    parameter int NUM_CLASSES = 26,
    parameter int CLS_W       = 5,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CLS_W-1:0] in_class,
    input  logic [DIM-1:0]   in_hv,
    input  logic             in_sub,
    input  logic             start_bin,
    input  logic             clear,
    output logic             out_valid,
    output logic [CLS_W-1:0] out_class,
    output logic [DIM-1:0]   out_hv,
    output logic             busy,
    output logic             err_class
);
    typedef enum logic {
        IDLE = 1'b0,
        BIN  = 1'b1
    } state_t;

    localparam logic [CLS_W:0]   NUM_CLS_EXT = (CLS_W+1)'(NUM_CLASSES);
    localparam logic [CLS_W-1:0] LAST_CLS    = CLS_W'(NUM_CLASSES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_q;
    logic [CLS_W-1:0] cls_q;
    logic             err_q;

    logic [CNT_W-1:0] acc_q [NUM_CLASSES][DIM];
    logic [CNT_W-1:0] acc_d [NUM_CLASSES][DIM];
    logic [CNT_W-1:0] n_q   [NUM_CLASSES];
    logic [CNT_W-1:0] n_d   [NUM_CLASSES];

    logic accept;
    logic cls_ok;

    // Saturating +/-1 step; counters never wrap in either direction.
    function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] v,
                                                  input logic             en,
                                                  input logic             sub);
        if (!en) begin
            return v;
        end
        if (sub) begin
            return (v == '0) ? v : v - CNT_ONE;
        end
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // Clear blocks acceptance so a sample offered alongside it is dropped, not half-applied.
    assign in_ready = (state_q == IDLE) & ~rst & ~clear;
    assign accept   = in_valid & in_ready;
    assign cls_ok   = ({1'b0, in_class} < NUM_CLS_EXT);

    always_comb begin
        acc_d = acc_q;
        n_d   = n_q;
        if (clear) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                n_d[c] = '0;
                for (int d = 0; d < DIM; d++) begin
                    acc_d[c][d] = '0;
                end
            end
        end else if (accept && cls_ok) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                if (in_class == CLS_W'(c)) begin
                    n_d[c] = sat_step(n_q[c], 1'b1, in_sub);
                    for (int d = 0; d < DIM; d++) begin
                        acc_d[c][d] = sat_step(acc_q[c][d], in_hv[d], in_sub);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                n_q[c] <= '0;
                for (int d = 0; d < DIM; d++) begin
                    acc_q[c][d] <= '0;
                end
            end
        end else begin
            acc_q <= acc_d;
            n_q   <= n_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cls_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept & ~cls_ok;
            if (clear) begin
                state_q <= IDLE;
                cls_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_bin) begin
                            state_q <= BIN;
                            cls_q   <= '0;
                        end
                    end
                    BIN: begin
                        if (cls_q == LAST_CLS) begin
                            state_q <= IDLE;
                            cls_q   <= '0;
                        end else begin
                            cls_q <= cls_q + CLS_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cls_q   <= '0;
                    end
                endcase
            end
        end
    end

    // Outputs are gated by rst so an asserted reset silences the readout in the same cycle.
    assign out_valid = (state_q == BIN) & ~rst;
    assign busy      = out_valid;
    assign err_class = err_q & ~rst;
    assign out_class = out_valid ? cls_q : '0;

    // Majority threshold: bit set when the class saw the bit in more than half its samples.
    always_comb begin
        out_hv = '0;
        if (out_valid) begin
            for (int d = 0; d < DIM; d++) begin
                out_hv[d] = ({acc_q[cls_q][d], 1'b0} > {1'b0, n_q[cls_q]});
            end
        end
    end
endmodule

// File: tb/tb_class_hv_accumulator.sv
// tb/tb_class_hv_accumulator.sv - self-checking bench for class_hv_accumulator
module tb_class_hv_accumulator;
    localparam int DIM   = 50;
    localparam int NC    = 26;
    localparam int CLS_W = 5;
    localparam int CNT_W = 8;
    localparam int CMAX  = 255;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [CLS_W-1:0] in_class;
    logic [DIM-1:0]   in_hv;
    logic             in_sub;
    logic             start_bin;
    logic             clear;
    logic             out_valid;
    logic [CLS_W-1:0] out_class;
    logic [DIM-1:0]   out_hv;
    logic             busy;
    logic             err_class;

    always #5 clk = ~clk;

    class_hv_accumulator #(
        .DIM(DIM), .NUM_CLASSES(NC), .CLS_W(CLS_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_hv(in_hv), .in_sub(in_sub),
        .start_bin(start_bin), .clear(clear), .out_valid(out_valid),
        .out_class(out_class), .out_hv(out_hv), .busy(busy), .err_class(err_class)
    );

    int checks = 0;
    int errors = 0;

    int m_acc [NC][DIM];
    int m_n   [NC];
    bit m_bin;
    int m_cls;
    bit m_err;

    logic [DIM-1:0] rd   [NC];
    logic [DIM-1:0] snap [NC];
    int             rd_cnt;

    typedef struct {
        logic [CLS_W-1:0] cls;
        logic [DIM-1:0]   hv;
        logic             sub;
        logic             exp_err;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_zero();
        for (int c = 0; c < NC; c++) begin
            m_n[c] = 0;
            for (int d = 0; d < DIM; d++) m_acc[c][d] = 0;
        end
    endtask

    task automatic m_update(input int c, input logic [DIM-1:0] hv, input logic sub);
        if (sub) begin
            if (m_n[c] > 0) m_n[c]--;
        end else if (m_n[c] < CMAX) begin
            m_n[c]++;
        end
        for (int d = 0; d < DIM; d++) begin
            if (hv[d]) begin
                if (sub) m_acc[c][d] = (m_acc[c][d] > 0) ? m_acc[c][d] - 1 : 0;
                else     m_acc[c][d] = (m_acc[c][d] < CMAX) ? m_acc[c][d] + 1 : CMAX;
            end
        end
    endtask

    function automatic logic [DIM-1:0] m_hv(input int c);
        logic [DIM-1:0] r;
        r = '0;
        for (int d = 0; d < DIM; d++) r[d] = (2 * m_acc[c][d] > m_n[c]);
        return r;
    endfunction

    task automatic check_outputs();
        chk("out_valid", out_valid, m_bin);
        chk("busy", busy, m_bin);
        chk("out_class", out_class, m_bin ? m_cls : 0);
        chk("out_hv", out_hv, m_bin ? m_hv(m_cls) : '0);
        chk("err_class", err_class, m_err);
    endtask

    task automatic tick();
        bit acc_ok;
        #1;
        chk("in_ready", in_ready, !m_bin && !rst && !clear);
        acc_ok = in_valid && !m_bin && !rst && !clear;
        @(posedge clk);
        if (rst) begin
            m_zero();
            m_bin = 0; m_cls = 0; m_err = 0;
        end else begin
            m_err = acc_ok && (in_class >= NC);
            if (clear) begin
                m_zero();
                m_bin = 0; m_cls = 0;
            end else begin
                if (acc_ok && in_class < NC) m_update(int'(in_class), in_hv, in_sub);
                if (m_bin) begin
                    if (m_cls == NC - 1) begin m_bin = 0; m_cls = 0; end
                    else m_cls++;
                end else if (start_bin) begin
                    m_bin = 1; m_cls = 0;
                end
            end
        end
        #1;
        if (out_valid) begin
            if (out_class < NC) rd[out_class] = out_hv;
            rd_cnt++;
        end
        check_outputs();
    endtask

    task automatic send(input int c, input logic [DIM-1:0] hv, input logic sub);
        in_valid = 1'b1;
        in_class = CLS_W'(c);
        in_hv    = hv;
        in_sub   = sub;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic readout(input bit with_sample, input int c, input logic [DIM-1:0] hv);
        rd_cnt = 0;
        for (int i = 0; i < NC; i++) rd[i] = '1;
        start_bin = 1'b1;
        if (with_sample) begin
            in_valid = 1'b1; in_class = CLS_W'(c); in_hv = hv; in_sub = 1'b0;
        end
        tick();
        start_bin = 1'b0;
        in_valid  = 1'b0;
        for (int i = 0; i < NC; i++) tick();
        chk("readout_count", rd_cnt, NC);
    endtask

    task automatic chk_all_zero(input string name);
        for (int i = 0; i < NC; i++) chk(name, rd[i], '0);
    endtask

    initial begin
        logic [63:0] r64;
        vecs[0] = '{cls: 5'd26, hv: '1,        sub: 1'b0, exp_err: 1'b1};
        vecs[1] = '{cls: 5'd3,  hv: 50'h3,     sub: 1'b0, exp_err: 1'b0};
        vecs[2] = '{cls: 5'd31, hv: '1,        sub: 1'b1, exp_err: 1'b1};
        vecs[3] = '{cls: 5'd25, hv: 50'hF0,    sub: 1'b0, exp_err: 1'b0};
        vecs[4] = '{cls: 5'd0,  hv: 50'h1,     sub: 1'b1, exp_err: 1'b0};
        vecs[5] = '{cls: 5'd27, hv: 50'h2,     sub: 1'b0, exp_err: 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_class = '0; in_hv = '0; in_sub = 1'b0;
        start_bin = 1'b0; clear = 1'b0;
        m_zero(); m_bin = 0; m_cls = 0; m_err = 0; rd_cnt = 0;

        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_class", out_class, '0);
        chk("rst_out_hv", out_hv, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_class, 1'b0);
        readout(0, 0, '0);
        chk_all_zero("rst_readout");

        for (int i = 0; i < 35; i++) send(3, 50'hFF, 1'b0);
        for (int i = 0; i < 40; i++) send(5, 50'h5, 1'b0);
        readout(0, 0, '0);
        chk("acc_class3", rd[3], 50'hFF);
        chk("acc_class5", rd[5], 50'h5);
        chk("acc_class0", rd[0], '0);
        chk("acc_class25", rd[25], '0);

        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 300; i++) send(0, '1, 1'b0);
        readout(0, 0, '0);
        chk("sat_add_class0", rd[0], {DIM{1'b1}});
        for (int i = 0; i < 300; i++) send(0, '1, 1'b1);
        readout(0, 0, '0);
        chk("sat_sub_class0", rd[0], '0);

        for (int i = 0; i < 6; i++) send(4, 50'h3C, 1'b0);
        readout(0, 0, '0);
        for (int i = 0; i < NC; i++) snap[i] = rd[i];
        send(26, '1, 1'b0);
        chk("range_err_pulse", err_class, 1'b1);
        tick();
        chk("range_err_clear", err_class, 1'b0);
        readout(0, 0, '0);
        for (int i = 0; i < NC; i++) chk("range_unchanged", rd[i], snap[i]);

        for (int i = 0; i < 6; i++) begin
            send(int'(vecs[i].cls), vecs[i].hv, vecs[i].sub);
            chk("vec_err", err_class, vecs[i].exp_err);
            tick();
            chk("vec_err_after", err_class, 1'b0);
        end
        readout(0, 0, '0);

        clear = 1'b1; tick(); clear = 1'b0;
        readout(1, 1, 50'h1);
        chk("simul_class1", rd[1], 50'h1);

        start_bin = 1'b1; tick(); start_bin = 1'b0;
        repeat (10) tick();
        chk("clear_at_cls10", out_class, 10);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clear_drops_valid", out_valid, 1'b0);
        readout(0, 0, '0);
        chk_all_zero("clear_readout");

        for (int i = 0; i < 20; i++) begin
            r64 = {$urandom(), $urandom()};
            send($urandom_range(0, NC - 1), r64[DIM-1:0], 1'b0);
        end
        start_bin = 1'b1; tick(); start_bin = 1'b0;
        repeat (7) tick();
        chk("rst_at_cls7", out_class, 7);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_mid_bin_valid", out_valid, 1'b0);
        #1;
        chk("rst_mid_bin_ready", in_ready, 1'b1);
        repeat (3) tick();
        readout(0, 0, '0);
        chk_all_zero("rst_mid_bin_readout");

        for (int i = 0; i < 1500; i++) begin
            r64 = {$urandom(), $urandom()};
            in_valid  = ($urandom_range(0, 3) != 0);
            in_class  = CLS_W'($urandom_range(0, 29));
            in_hv     = r64[DIM-1:0];
            in_sub    = ($urandom_range(0, 2) == 0);
            clear     = ($urandom_range(0, 199) == 0);
            start_bin = ($urandom_range(0, 79) == 0);
            rst       = ($urandom_range(0, 499) == 0);
            tick();
        end
        in_valid = 1'b0; clear = 1'b0; start_bin = 1'b0; rst = 1'b0;
        repeat (NC + 2) tick();
        readout(0, 0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
